// File: rtl/gray_seq_ctrl_pkg.sv
// Shared constants for the Gray-code sequencer: FSM state encoding and count limits.
package gray_seq_ctrl_pkg;

    localparam int unsigned GSC_WIDTH = 4;
    localparam int unsigned CNT_MAX   = (1 << GSC_WIDTH) - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder.
module bin_to_gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_fsm.sv
// Sequencer control: state register, run-parameter latches and registered busy/done/wrap flags.
module gray_seq_fsm
    import gray_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = GSC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step_en,
    input  logic             dir_up,
    input  logic             mode_wrap,
    input  logic [WIDTH-1:0] term_bin,
    input  logic             load_en,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] next_count,
    output logic             dir_q,
    output logic             load_c,
    output logic             step_c,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_TOP = {WIDTH{1'b1}};

    logic [1:0]       r_state;
    logic             r_dir;
    logic             r_mode;
    logic [WIDTH-1:0] r_term;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;

    logic [1:0]       w_state_nxt;
    logic             w_dir_nxt;
    logic             w_mode_nxt;
    logic [WIDTH-1:0] w_term_nxt;
    logic             w_wrap_nxt;

    // Next-state, latch updates and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode;
        w_term_nxt  = r_term;
        w_wrap_nxt  = 1'b0;
        load_c      = 1'b0;
        step_c      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_en) begin
                    load_c = 1'b1;
                end else if (start) begin
                    w_dir_nxt  = dir_up;
                    w_mode_nxt = mode_wrap;
                    w_term_nxt = term_bin;
                    w_state_nxt = (!mode_wrap && (count == term_bin)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (step_en) begin
                    step_c = 1'b1;
                    if (r_mode) begin
                        w_wrap_nxt = r_dir ? (count == CNT_TOP) : (count == '0);
                    end else if (next_count == r_term) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dir   <= 1'b1;
            r_mode  <= 1'b0;
            r_term  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_mode  <= w_mode_nxt;
            r_term  <= w_term_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign dir_q = r_dir;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wrap  = r_wrap;

endmodule

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code counter sequencer top: count register plus encode/decode converters around the control FSM.
module gray_seq_ctrl
    import gray_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = GSC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step_en,
    input  logic             dir_up,
    input  logic             mode_wrap,
    input  logic [WIDTH-1:0] term_bin,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic [WIDTH-1:0] w_load_bin;
    logic             w_dir;
    logic             w_load;
    logic             w_step;

    // Modulo step in the latched direction
    assign w_next_bin = w_dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

    gray_seq_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step_en    (step_en),
        .dir_up     (dir_up),
        .mode_wrap  (mode_wrap),
        .term_bin   (term_bin),
        .load_en    (load_en),
        .count      (r_count),
        .next_count (w_next_bin),
        .dir_q      (w_dir),
        .load_c     (w_load),
        .step_c     (w_step),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    bin_to_gray #(.WIDTH(WIDTH)) u_enc (
        .bin  (w_next_bin),
        .gray (w_next_gray)
    );

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (load_gray),
        .bin  (w_load_bin)
    );

    // Binary and Gray registers always update together so the pair never disagrees
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_gray  <= '0;
        end else if (w_load) begin
            r_count <= w_load_bin;
            r_gray  <= load_gray;
        end else if (w_step) begin
            r_count <= w_next_bin;
            r_gray  <= w_next_gray;
        end
    end

    assign gray_out = r_gray;
    assign bin_out  = r_count;

endmodule
